// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared types, constants and the rotating-priority search helper
// for the four-requester round-robin arbiter.
//   state_e     - arbiter FSM state (IDLE / GRANT)
//   arb_pick_t  - result of one arbitration search (found flag + winning index)
//   rr_pick()   - search req starting at last+1, wrapping mod N_REQ
package rr_arb4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    // Pointer value after reset: client 0 becomes highest priority.
    localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } arb_pick_t;

    // Scan last+4 down to last+1 so the earliest candidate in rotating order
    // is the one left standing; last+4 wraps to last itself.
    function automatic arb_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [IDX_W-1:0] last);
        arb_pick_t        res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int i = int'(N_REQ); i >= 1; i--) begin
            cand = last + IDX_W'(i);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// rr_arb4_if: request/grant bundle between the clients and the arbiter.
//   req     - request lines, one per client
//   gnt     - one-hot grant (or zero)
//   gnt_idx - binary index of current / last grantee
//   busy    - high while a grant is held
//   timeout - one-cycle pulse when a grant is forcibly revoked
// Modports: master = client side, slave = arbiter side.
interface rr_arb4_if;
    import rr_arb4_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_arb4_dec2to4.sv
// dec2to4: combinational 2-to-4 decoder with enable.
//   en - enable; when low, y is all zero
//   w  - binary select
//   y  - one-hot of w when enabled
module dec2to4 (
    input  logic       en,
    input  logic [1:0] w,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with grant hold limit.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - rr_arb4_if.slave: req in; gnt, gnt_idx, busy, timeout out
// Parameters:
//   MAX_HOLD - maximum grant length in cycles (0 disables the limit)
//   CW       - hold counter width, 2**CW >= MAX_HOLD
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    rr_arb4_if.slave   bus
);

    localparam bit          HOLD_EN = (MAX_HOLD != 0);
    // Saturation point of the hold counter; with no limit it just parks at all-ones.
    localparam logic [CW-1:0] CNT_MAX = HOLD_EN ? CW'(MAX_HOLD - 1) : {CW{1'b1}};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             timeout_q, timeout_d;
    arb_pick_t        pick;

    assign pick = rr_pick(bus.req, last_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold / release / revoke in GRANT.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick.found) begin
                    idx_d   = pick.idx;
                    last_d  = pick.idx;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Voluntary release takes precedence over the hold limit.
                if (!bus.req[idx_q]) begin
                    state_d = S_IDLE;
                end else if (HOLD_EN && (cnt_q == CNT_MAX)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant vector is decoded from registered state only.
    dec2to4 u_dec (
        .en (state_q == S_GRANT),
        .w  (idx_q),
        .y  (bus.gnt)
    );

    assign bus.gnt_idx = idx_q;
    assign bus.busy    = (state_q == S_GRANT);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;
    import rr_arb4_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    rr_arb4_if arb_if ();

    rr_arb4 #(
        .MAX_HOLD (8),
        .CW       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check gnt, busy (= OR of expected gnt) and timeout together.
    task automatic chk_out(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
        chk({tag, ".gnt"},     8'(arb_if.gnt),     8'(exp_gnt));
        chk({tag, ".busy"},    8'(arb_if.busy),    8'(|exp_gnt));
        chk({tag, ".timeout"}, 8'(arb_if.timeout), 8'(exp_to));
    endtask

    initial begin
        logic [3:0] g_exp;
        logic [3:0] g_nxt;
        tests = 0;
        fails = 0;

        // Reset priority
        rst = 1'b1;
        arb_if.req = 4'b1111;
        step(2);
        chk_out("reset", 4'b0000, 1'b0);
        chk("reset.idx", 8'(arb_if.gnt_idx), 8'd0);
        rst = 1'b0;
        step(1);
        chk_out("first_grant", 4'b0001, 1'b0);
        chk("first_grant.idx", 8'(arb_if.gnt_idx), 8'd0);

        // Rotation: 0 -> 1 -> 2 -> 3 -> 0, one IDLE cycle between grants
        for (int g = 0; g < 4; g++) begin
            g_exp = 4'b0001 << g;
            g_nxt = 4'b0001 << ((g + 1) % 4);
            step(1);
            chk_out("rot_hold", g_exp, 1'b0);
            arb_if.req = 4'b1111 & ~g_exp;
            step(1);
            chk_out("rot_idle", 4'b0000, 1'b0);
            arb_if.req = 4'b1111;
            step(1);
            chk_out("rot_next", g_nxt, 1'b0);
            chk("rot_next.idx", 8'(arb_if.gnt_idx), 8'((g + 1) % 4));
        end
        arb_if.req = 4'b0000;
        step(1);
        chk_out("rot_end", 4'b0000, 1'b0);

        // Timeout: client 2 held for exactly 8 cycles
        arb_if.req = 4'b0100;
        step(1);
        chk_out("to_c1", 4'b0100, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            step(1);
            chk_out("to_hold", 4'b0100, 1'b0);
        end
        step(1);
        chk_out("to_pulse", 4'b0000, 1'b1);
        step(1);
        chk_out("to_regrant", 4'b0100, 1'b0);
        chk("to_regrant.idx", 8'(arb_if.gnt_idx), 8'd2);

        // Fairness: client 2 times out, client 0 must be served next
        arb_if.req = 4'b0101;
        step(7);
        chk_out("fair_c8", 4'b0100, 1'b0);
        step(1);
        chk_out("fair_to", 4'b0000, 1'b1);
        step(1);
        chk_out("fair_c0", 4'b0001, 1'b0);
        chk("fair_c0.idx", 8'(arb_if.gnt_idx), 8'd0);
        arb_if.req = 4'b0100;
        step(1);
        chk_out("fair_idle", 4'b0000, 1'b0);
        step(1);
        chk_out("fair_c2", 4'b0100, 1'b0);

        // Release on the same edge the counter hits the limit
        step(7);
        chk_out("sim_c8", 4'b0100, 1'b0);
        arb_if.req = 4'b0000;
        step(1);
        chk_out("sim_rel", 4'b0000, 1'b0);
        step(1);
        chk_out("sim_after", 4'b0000, 1'b0);

        // Reset mid-grant
        arb_if.req = 4'b1000;
        step(1);
        chk_out("mid_c3", 4'b1000, 1'b0);
        chk("mid_c3.idx", 8'(arb_if.gnt_idx), 8'd3);
        rst = 1'b1;
        step(1);
        chk_out("mid_rst", 4'b0000, 1'b0);
        chk("mid_rst.idx", 8'(arb_if.gnt_idx), 8'd0);
        chk("mid_rst.last", 8'(dut.last_q), 8'd3);
        rst = 1'b0;
        arb_if.req = 4'b1001;
        step(1);
        chk_out("mid_regrant", 4'b0001, 1'b0);
        chk("mid_regrant.idx", 8'(arb_if.gnt_idx), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that shares one resource, such as a common bus or display driver, among four clients. It picks the next requester in rotating order and holds the grant until that requester drops its request or a hold limit expires. The winning index drives a 2-to-4 decoder with enable, which produces the one-hot grant vector. It sits between the lab's request sources and the shared datapath, and it is the sequencing layer for the decoder.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant may be held. A value of 0 disables the timeout.
- `CW`, default 4: width of the hold counter. It must satisfy 2^CW ≥ MAX_HOLD.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, 4: request lines. `req[i]`=1 means client i wants the resource.
- `gnt`, output, 4: one-hot grant, or all zero. This is the decoder output.
- `gnt_idx`, output, 2: binary index of the current or last grantee.
- `busy`, output, 1: 1 while in state GRANT.
- `timeout`, output, 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- States:
  - IDLE: no grant, `gnt`=0, decoder `en`=0.
  - GRANT: decoder `en`=1 with `w`=`gnt_idx`.
- The pointer `last` (2 bits) holds the index of the most recent grantee.
- Arbitration in IDLE:
  - If `req` is nonzero, search indices last+1, last+2, last+3, last+4, all mod 4, and select the first with `req` set.
  - The selected index loads into `gnt_idx` and `last`.
  - The hold counter clears to 0 and the state moves to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT:
  - The counter increments every cycle and saturates at MAX_HOLD-1.
  - Normal release: if `req[gnt_idx]`=0, go to IDLE.
  - Forced release: if MAX_HOLD≠0, counter = MAX_HOLD-1 and `req[gnt_idx]`=1, go to IDLE and assert `timeout` for that one cycle.
  - If both release conditions are true in the same cycle, normal release wins and `timeout` stays 0.
  - Requests from other clients during GRANT are ignored. Their lines must stay high to be served later.
- Fairness: after any release, the previous grantee is lowest priority in the next arbitration. A timed-out client therefore waits at most 3 other grants before it is served again.
- Arithmetic: the pointer wraps 3→0 with 2-bit modular addition. The counter is unsigned CW bits and never wraps.
- Reset values:
  - `gnt`=0000, `gnt_idx`=00, `busy`=0, `timeout`=0.
  - State = IDLE, counter = 0.
  - `last`=3, so that client 0 has highest priority after reset.
- Reset mid-grant: the grant drops on the reset edge and the cycle after shows `gnt`=0. No `timeout` pulse is generated.

## Timing
- Grant latency: a request seen at edge k (state IDLE) gives `gnt` valid after edge k. That is one cycle, registered.
- Release latency: `req[gnt_idx]` low at edge k gives `gnt`=0 after edge k.
- Turnaround: there is one mandatory IDLE cycle between consecutive grants. The minimum period between different grantees is therefore 2 cycles plus the hold time.
- Timeout: with `req` held, the grant lasts exactly MAX_HOLD cycles. `gnt`=0 and `timeout`=1 occur together in the following cycle.
- All outputs are registered or decoded from registered state. There are no combinational paths from `req` to any output.
- `busy` equals the OR of all `gnt` bits in every cycle.

## Structure
- Shared include `arb_defs.vh` holds:
  - State encodings: `S_IDLE`=1'b0, `S_GRANT`=1'b1.
  - `N_REQ`=4.
  - The reset pointer value `LAST_RST`=2'd3.
- Sub-module `dec2to4`: purely combinational, ports (`en`, `w[1:0]`, `y[3:0]`).
  - `y` = one-hot of `w` when `en`=1, else 0.
  - It is instantiated once to drive `gnt`.
- The remaining logic sits in `rr_arb4`: the FSM, the pointer, the rotating priority search, the hold counter and the timeout flag.

## Test plan
- **Reset priority:** assert `rst`, then release it with `req`=1111.
  - Expect `gnt`=0001 and `gnt_idx`=0 one cycle after the first non-reset edge.
  - Reset outputs must read all zero.
- **Rotation:** hold `req`=1111 and drop each grantee's request for one cycle after 2 cycles of grant.
  - Expect the grant order 0001, 0010, 0100, 1000, 0001, with exactly one IDLE cycle (`gnt`=0000) between grants.
- **Timeout:** MAX_HOLD=8, `req`=0100 held.
  - Expect `gnt`=0100 for exactly 8 cycles, then `gnt`=0000 with `timeout`=1 for one cycle, then a regrant of 0100.
- **Fairness after timeout:** `req`=0101 held, with client 2 timing out first.
  - Expect the next grant 0001 (client 0) before client 2 is served again.
- **Simultaneous release and limit:** drop `req[gnt_idx]` on the same cycle the counter reaches MAX_HOLD-1.
  - Expect `gnt`=0000 and `timeout`=0.
- **Reset mid-grant:** while `gnt`=1000, pulse `rst` for one cycle.
  - Expect `gnt`=0000, `last`=3 and no `timeout`, and the next request from client 0 to be granted first.
